// File: rtl/spart_pkg.sv
// Shared constants and state encodings for the SPART bus peripheral.
// Bus addresses, oversample ratio, status bit positions and FSM states.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int OVERSAMPLE = 16;
  // Last tick of a bit period and the tick that lands mid-bit.
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

  localparam int STAT_TBR = 0;
  localparam int STAT_RDA = 1;
  localparam int STAT_OVR = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud divisor register and 16x oversample tick generator.
// Down-counter ticks at zero and reloads, giving a period of divisor+1 clocks.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd651
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [7:0]  wdata,
  output logic [15:0] divisor,
  output logic        tick
);

  logic [15:0] div_reg;
  logic [15:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg   <= DIV_RESET;
      count_reg <= DIV_RESET;
    end else begin
      if (wr_hi) div_reg[15:8] <= wdata;
      // Low-byte write completes the divisor, so restart the count from it.
      if (wr_lo) begin
        div_reg[7:0] <= wdata;
        count_reg    <= {div_reg[15:8], wdata};
      end else if (count_reg == '0) begin
        count_reg <= div_reg;
      end else begin
        count_reg <= count_reg - 16'd1;
      end
    end
  end

  assign tick    = (count_reg == '0);
  assign divisor = div_reg;

endmodule

// File: rtl/spart_core.sv
// SPART bus peripheral: divisor registers, 8N1 transmitter and receiver, status.
// Optional overrun flag enabled with the SPART_OVERRUN_EN macro.
module spart_core
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_RESET   = 16'd651,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  logic        bus_rd, bus_wr, wr_buf, rd_buf, rd_stat, tick, ovr;
  logic [15:0] divisor;
  logic [7:0]  rd_data, status;

  assign bus_rd  = iocs & iorw;
  assign bus_wr  = iocs & ~iorw;
  assign wr_buf  = bus_wr & (ioaddr == ADDR_BUF) & tbr;
  assign rd_buf  = bus_rd & (ioaddr == ADDR_BUF);
  assign rd_stat = bus_rd & (ioaddr == ADDR_STAT);

  spart_baud_gen #(.DIV_RESET(DIV_RESET)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_lo   (bus_wr & (ioaddr == ADDR_DBL)),
    .wr_hi   (bus_wr & (ioaddr == ADDR_DBH)),
    .wdata   (databus),
    .divisor (divisor),
    .tick    (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t   tx_state_reg, tx_state_next;
  logic [3:0]  tx_cnt_reg, tx_cnt_next;
  logic [2:0]  tx_bit_reg, tx_bit_next;
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic        tx_wait_reg, tx_wait_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_wait_reg  <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_wait_reg  <= tx_wait_next;
    end
  end

  // tx_wait holds the line idle until the first tick so every bit gets 16 full ticks.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_wait_next  = tx_wait_reg;
    case (tx_state_reg)
      TX_IDLE: begin
        if (wr_buf) begin
          tx_state_next = TX_START;
          tx_shift_next = databus;
          tx_wait_next  = 1'b1;
          tx_cnt_next   = '0;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_wait_reg) begin
            tx_wait_next = 1'b0;
          end else if (tx_cnt_reg == TICK_LAST) begin
            tx_state_next = TX_DATA;
            tx_cnt_next   = '0;
            tx_bit_next   = '0;
          end else begin
            tx_cnt_next = tx_cnt_reg + 4'd1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_cnt_reg == TICK_LAST) begin
            tx_cnt_next   = '0;
            tx_shift_next = {1'b0, tx_shift_reg[7:1]};
            if (tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
            else                    tx_bit_next   = tx_bit_reg + 3'd1;
          end else begin
            tx_cnt_next = tx_cnt_reg + 4'd1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_cnt_reg == TICK_LAST) tx_state_next = TX_IDLE;
          else                         tx_cnt_next   = tx_cnt_reg + 4'd1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  assign tbr = (tx_state_reg == TX_IDLE);
  assign txd = ~((tx_state_reg == TX_START) & ~tx_wait_reg) &
               ((tx_state_reg != TX_DATA) | tx_shift_reg[0]);

  // ---------------- receiver ----------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= '1;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], rxd};
  end
  assign rx_s = sync_reg[SYNC_STAGES-1];

  rx_state_t  rx_state_reg, rx_state_next;
  logic [3:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0] rx_bit_reg, rx_bit_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic [7:0] rx_buf_reg, rx_buf_next;
  logic       rda_reg, rda_next;
  logic       byte_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_buf_reg   <= '0;
      rda_reg      <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_buf_reg   <= rx_buf_next;
      rda_reg      <= rda_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    byte_done     = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (tick && !rx_s) begin
          rx_state_next = RX_START;
          rx_cnt_next   = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          // Mid start bit: a high line here was only a glitch.
          if (rx_cnt_reg == TICK_MID) begin
            rx_state_next = rx_s ? RX_IDLE : RX_DATA;
            rx_cnt_next   = '0;
            rx_bit_next   = '0;
          end else begin
            rx_cnt_next = rx_cnt_reg + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_cnt_reg == TICK_LAST) begin
            rx_cnt_next   = '0;
            rx_shift_next = {rx_s, rx_shift_reg[7:1]};
            if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
            else                    rx_bit_next   = rx_bit_reg + 3'd1;
          end else begin
            rx_cnt_next = rx_cnt_reg + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_cnt_reg == TICK_LAST) begin
            rx_state_next = RX_IDLE;
            byte_done     = rx_s;
          end else begin
            rx_cnt_next = rx_cnt_reg + 4'd1;
          end
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // A completing byte beats a simultaneous buffer read.
  assign rx_buf_next = byte_done ? rx_shift_reg : rx_buf_reg;
  assign rda_next    = byte_done | (rda_reg & ~rd_buf);
  assign rda         = rda_reg;

`ifdef SPART_OVERRUN_EN
  logic ovr_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovr_reg <= 1'b0;
    else if (byte_done & rda_reg) ovr_reg <= 1'b1;
    else if (rd_stat)            ovr_reg <= 1'b0;
  end
  assign ovr = ovr_reg;
`else
  assign ovr = 1'b0;
`endif

  // ---------------- bus read ----------------
  always_comb begin
    status           = '0;
    status[STAT_TBR] = tbr;
    status[STAT_RDA] = rda_reg;
    status[STAT_OVR] = ovr;
  end

  always_comb begin
    rd_data = '0;
    case (ioaddr)
      ADDR_BUF:  rd_data = rx_buf_reg;
      ADDR_STAT: rd_data = status;
      ADDR_DBL:  rd_data = divisor[7:0];
      default:   rd_data = divisor[15:8];
    endcase
  end

  assign databus = bus_rd ? rd_data : 8'bz;

endmodule

// File: tb/tb_spart_core.sv
// Scoreboard bench for spart_core: random TX/RX bytes checked against a serial-frame model.
// Build with or without SPART_OVERRUN_EN; the model follows the same macro.
module tb_spart_core;
  import spart_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0, iocs = 1'b0, iorw = 1'b0, rxd = 1'b1;
  logic [1:0] ioaddr = 2'b00;
  logic       drv_en = 1'b0;
  logic [7:0] drv_data = 8'h00;
  wire  [7:0] databus;
  logic       rda, tbr, txd;

  assign databus = drv_en ? drv_data : 8'bz;

  spart_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  exp_tx[$];
  logic [7:0]  exp_rx[$];
  logic [15:0] div_m = 16'd651;
  logic        rda_m = 1'b0;
  logic        ovr_m = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_en = 1'b1; drv_data = d;
    @(posedge clk);
    #1;
    iocs = 1'b0; drv_en = 1'b0;
    if (a == ADDR_DBL) div_m[7:0]  = d;
    if (a == ADDR_DBH) div_m[15:8] = d;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1;
    d = databus;
    @(posedge clk);
    #1;
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic read_check(input logic [1:0] a);
    logic [7:0] d, e;
    bus_read(a, d);
    case (a)
      ADDR_BUF: begin
        if (exp_rx.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_scoreboard_empty: read %h, no byte expected", d);
        end else begin
          e = exp_rx.pop_front();
          check("rx_byte", {8'h00, d}, {8'h00, e});
        end
        rda_m = 1'b0;
        check("rda_clear_after_read", {15'd0, rda}, {15'd0, rda_m});
        $display("rx read byte=%h", d);
      end
      ADDR_STAT: begin
        e = {5'b0, ovr_m, rda_m, 1'b1};
        check("status", {8'h00, d}, {8'h00, e});
        ovr_m = 1'b0;
        $display("status read %h", d);
      end
      ADDR_DBL: check("div_lo", {8'h00, d}, {8'h00, div_m[7:0]});
      default:  check("div_hi", {8'h00, d}, {8'h00, div_m[15:8]});
    endcase
  endtask

  // Serial 8N1 frame on rxd at the current model baud rate.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    int bc;
    bc = 16 * (int'(div_m) + 1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bc) @(negedge clk);
    end
    rxd = stop;
    repeat (bc) @(negedge clk);
    rxd = 1'b1;
    repeat (bc) @(negedge clk);
    if (stop) begin
`ifdef SPART_OVERRUN_EN
      if (rda_m) ovr_m = 1'b1;
`endif
      if (rda_m) exp_rx.delete();
      exp_rx.push_back(b);
      rda_m = 1'b1;
    end
    check("rda_after_frame", {15'd0, rda}, {15'd0, rda_m});
    $display("rx frame sent byte=%h stop=%0d", b, stop);
  endtask

  task automatic wait_tbr();
    int k;
    k = 0;
    while (tbr !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("tbr_wait_timeout", {15'd0, tbr}, 16'd1);
  endtask

  // Held read of the buffer across the frame end: the read edge that coincides with
  // byte completion must leave rda set and present the new byte.
  task automatic hold_read(input logic [7:0] b);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = ADDR_BUF;
    for (int k = 0; k < 1200 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (rda === 1'b1) begin
        seen = 1'b1;
        check("coincident_read_data", {8'h00, databus}, {8'h00, b});
      end
    end
    iocs = 1'b0; iorw = 1'b0;
    check("coincident_rda_set", {15'd0, seen}, 16'd1);
  endtask

  // TX monitor: decodes each frame on txd and compares it with the scoreboard.
  initial begin
    logic       txd_prev;
    logic [7:0] got;
    logic       sbit, pbit;
    int         bc, k;
    txd_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && txd_prev && !txd && exp_tx.size() > 0) begin
        bc = 16 * (int'(div_m) + 1);
        repeat (bc / 2) @(negedge clk);
        sbit = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (bc) @(negedge clk);
          got[i] = txd;
        end
        repeat (bc) @(negedge clk);
        pbit = txd;
        k = 0;
        while (tbr !== 1'b1 && k < 2 * bc) begin
          @(negedge clk);
          k++;
        end
        check("tx_start_bit", {15'd0, sbit}, 16'd0);
        check("tx_byte", {8'h00, got}, {8'h00, exp_tx.pop_front()});
        check("tx_stop_bit", {15'd0, pbit}, 16'd1);
        check("tx_frame_clks", 16'(bc / 2 + 9 * bc + k), 16'(10 * bc));
        $display("tx frame byte=%h", got);
      end
      txd_prev = txd;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    int         k;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_tbr", {15'd0, tbr}, 16'd1);
    check("reset_txd", {15'd0, txd}, 16'd1);
    check("reset_rda", {15'd0, rda}, 16'd0);
    read_check(ADDR_STAT);
    read_check(ADDR_DBL);
    read_check(ADDR_DBH);

    // Reset in the middle of a transmit frame (not scoreboarded: it never completes)
    bus_write(ADDR_BUF, 8'hC3);
    k = 0;
    while (txd !== 1'b0 && k < 1500) begin
      @(negedge clk);
      k++;
    end
    check("tx_started_before_reset", {15'd0, txd}, 16'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_txd", {15'd0, txd}, 16'd1);
    check("midframe_reset_tbr", {15'd0, tbr}, 16'd1);
    check("midframe_reset_rda", {15'd0, rda}, 16'd0);
    drv_en = 1'b1; drv_data = 8'h5A;
    #1;
    check("databus_released", {8'h00, databus}, 16'h005A);
    drv_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    div_m = 16'd651; rda_m = 1'b0; ovr_m = 1'b0;
    read_check(ADDR_STAT);

    // Divisor 2: tick every 3 clocks, 48 clocks per bit
    bus_write(ADDR_DBH, 8'h00);
    bus_write(ADDR_DBL, 8'h02);
    read_check(ADDR_DBL);
    read_check(ADDR_DBH);

    // Transmit: first byte 0x55, then random; a write while busy must be ignored
    for (int n = 0; n < 3; n++) begin
      b = (n == 0) ? 8'h55 : 8'($urandom_range(0, 255));
      exp_tx.push_back(b);
      bus_write(ADDR_BUF, b);
      check("tbr_low_after_load", {15'd0, tbr}, 16'd0);
      repeat (20) @(negedge clk);
      bus_write(ADDR_BUF, ~b);
      wait_tbr();
      repeat (5) @(negedge clk);
    end

    // Receive: fixed byte, false start, framing error, then good and random bytes
    send_rx(8'hA3, 1'b1);
    read_check(ADDR_BUF);
    @(negedge clk);
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    repeat (150) @(negedge clk);
    check("false_start_rda", {15'd0, rda}, 16'd0);
    send_rx(8'h5E, 1'b0);
    send_rx(8'h3C, 1'b1);
    read_check(ADDR_BUF);
    for (int n = 0; n < 3; n++) begin
      send_rx(8'($urandom_range(0, 255)), 1'b1);
      read_check(ADDR_BUF);
    end

    // Read on the same edge that a byte completes
    fork
      send_rx(8'h96, 1'b1);
      hold_read(8'h96);
    join
    read_check(ADDR_BUF);

    // Two bytes without a read: second overwrites the first
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    read_check(ADDR_STAT);
    read_check(ADDR_STAT);
    read_check(ADDR_BUF);
    read_check(ADDR_STAT);

    repeat (10) @(negedge clk);
    check("tx_scoreboard_drained", 16'(exp_tx.size()), 16'd0);
    check("rx_scoreboard_drained", 16'(exp_rx.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
